// File: rtl/sd_image_server.sv
// Sector server for the floppy controller's SD buffer port: moves one 512-byte
// sector per request between the controller buffer and byte-wide image memory.
module sd_image_server #(
  parameter int          AW      = 21,
  parameter logic [7:0]  FILL    = 8'hE5,
  parameter int          BUF_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sdRd,
  input  logic          sdWr,
  input  logic [31:0]   sdLba,
  output logic          sdAck,
  output logic [8:0]    sdA,
  output logic [7:0]    sdQ,
  output logic          sdW,
  input  logic [7:0]    sdD,
  input  logic [AW:0]   imgSz,
  output logic [AW-1:0] memA,
  output logic          memRd,
  output logic          memWr,
  output logic [7:0]    memD,
  input  logic [7:0]    memQ,
  input  logic          memRdy,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_DATA, WR_WAIT, DONE
  } state_t;

  state_t        st;
  logic [8:0]    idx;
  logic [AW-1:0] base;
  logic          oor;
  logic [3:0]    latc;

  // Range test runs at full 41-bit width so huge LBAs never alias into range.
  logic [40:0]   sec_start, sz41;
  logic          oor_now;
  logic [AW-1:0] addr;

  assign sec_start = {sdLba, 9'b0};
  assign sz41      = {{(40-AW){1'b0}}, imgSz};
  assign oor_now   = (imgSz == '0) || (sec_start >= sz41);
  assign addr      = base + {{(AW-9){1'b0}}, idx};

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= IDLE;
      idx   <= '0;
      base  <= '0;
      oor   <= 1'b0;
      latc  <= '0;
      sdAck <= 1'b0;
      sdA   <= '0;
      sdQ   <= '0;
      sdW   <= 1'b0;
      memA  <= '0;
      memRd <= 1'b0;
      memWr <= 1'b0;
      memD  <= '0;
      busy  <= 1'b0;
    end else begin
      sdW <= 1'b0;
      case (st)
        IDLE: if (sdRd || sdWr) begin
          base  <= sec_start[AW-1:0];
          oor   <= oor_now;
          idx   <= '0;
          sdA   <= '0;
          latc  <= '0;
          sdAck <= 1'b1;
          busy  <= 1'b1;
          st    <= sdRd ? RD_REQ : WR_ADDR;
        end
        // First cycle issues the access; memRdy only counts once memRd is up.
        RD_REQ: begin
          if (oor) begin
            sdQ <= FILL;
            sdA <= idx;
            sdW <= 1'b1;
            st  <= RD_PUT;
          end else if (!memRd) begin
            memA  <= addr;
            memRd <= 1'b1;
          end else if (memRdy) begin
            memRd <= 1'b0;
            sdQ   <= memQ;
            sdA   <= idx;
            sdW   <= 1'b1;
            st    <= RD_PUT;
          end
        end
        RD_PUT: begin
          if (idx == 9'd511) begin
            sdAck <= 1'b0;
            st    <= DONE;
          end else begin
            idx <= idx + 9'd1;
            st  <= RD_REQ;
          end
        end
        WR_ADDR: begin
          if (latc == 4'(BUF_LAT - 1)) st <= WR_DATA;
          else latc <= latc + 4'd1;
        end
        WR_DATA: begin
          memD  <= sdD;
          memA  <= addr;
          memWr <= !oor;
          st    <= WR_WAIT;
        end
        WR_WAIT: if (oor || memRdy) begin
          memWr <= 1'b0;
          if (idx == 9'd511) begin
            sdAck <= 1'b0;
            st    <= DONE;
          end else begin
            idx  <= idx + 9'd1;
            sdA  <= idx + 9'd1;
            latc <= '0;
            st   <= WR_ADDR;
          end
        end
        // Held request levels park here so they cannot retrigger.
        DONE: if (!sdRd && !sdWr) begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_image_server.md
Name: sd_image_server

Overview:
- Serves the sector-level SD buffer interface that the floppy controller drives (sector read/write request, LBA, 9-bit buffer address, byte strobes).
- Answers each request by moving one 512-byte sector between the controller's sector buffer and a byte-wide backing memory holding the mounted disk image (SDRAM/BRAM arbiter port).
- Sits between the floppy controller and the image memory in the Lynx top level, in place of a host-side SD bridge.

Parameters:
- AW, 21, backing-memory byte-address width; the image is at most 2^AW bytes.
- FILL, 8'hE5, byte returned for sectors outside the mounted image.
- BUF_LAT, 1, cycles from sdA change to valid sdD, set by the controller's buffer RAM read latency.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sdRd  in  1  sector read request, level.
- sdWr  in  1  sector write request, level.
- sdLba  in  32  sector number, sampled at acceptance.
- sdAck  out  1  request accepted / transfer in progress.
- sdA  out  9  byte index into the controller's sector buffer.
- sdQ  out  8  byte to the controller buffer (read direction).
- sdW  out  1  one-cycle write strobe into the controller buffer.
- sdD  in  8  byte from the controller buffer (write direction).
- imgSz  in  AW+1  mounted image size in bytes; 0 means no image.
- memA  out  AW  backing-memory byte address.
- memRd  out  1  memory read request; held until memRdy.
- memWr  out  1  memory write request; held until memRdy.
- memD  out  8  memory write data.
- memQ  in  8  memory read data; valid in the memRdy cycle.
- memRdy  in  1  single-cycle completion of the current access.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, latched LBA 0.
  - Reset mid-transfer aborts immediately: sdAck, memRd and memWr drop the next cycle.
- IDLE: a request is accepted in a cycle where sdRd or sdWr is high.
  - If both are high, the read wins.
  - At acceptance: latch base = sdLba*512, truncated to AW bits; clear index.
  - At acceptance: set oor = (imgSz == 0) or ({sdLba,9'b0} >= imgSz), comparison done at full 41-bit width.
  - sdAck rises the cycle after acceptance and stays high until DONE.
- Read path, per index i = 0..511:
  - RD_REQ: memA = base+i, memRd = 1; hold until memRdy.
  - On memRdy: sdQ <= memQ, sdA <= i, sdW = 1 for exactly one cycle (RD_PUT).
  - If oor: no memory access; sdQ = FILL, strobe issued one cycle after entry.
  - After i = 511, go to DONE; otherwise increment i and return to RD_REQ.
  - At most one sdW per byte; never two in consecutive cycles.
- Write path, per index i:
  - WR_ADDR: drive sdA = i, wait BUF_LAT cycles.
  - WR_DATA: capture sdD into memD.
  - WR_WAIT: memA = base+i, memWr = 1; hold until memRdy.
  - If oor: skip the memory write (data discarded); proceed to the next index.
  - After i = 511, go to DONE.
- memRd and memWr are never high together. memA, memD and the request stay stable while waiting.
- memRdy arriving outside a pending access is ignored.
- DONE: sdAck = 0. Return to IDLE only when sdRd and sdWr are both low, so a held level never retriggers.
- Index is 9 bits. No wrap past 511 within a sector. base+i wraps modulo 2^AW.
- imgSz and sdLba changes after acceptance do not affect the current transfer.
- Throughput: a read with zero-wait memory costs 3 cycles/byte.

Test Plan:
- Read LBA 2, imgSz=4096, memory byte k = k[7:0]: 512 sdW strobes, sdA 0..511 in order, sdQ = (1024+i)[7:0], memA 1024..1535, then sdAck=0.
- Write LBA 1, buffer byte i = ~i[7:0], BUF_LAT=1, memRdy 3 cycles after each request: memory 512..1023 holds ~i; no memRd seen.
- Read LBA 8 with imgSz=4096 (out of range): 512 bytes of 0xE5, zero memRd; write LBA 8: zero memWr, sdAck still completes.
- sdRd and sdWr high in the same cycle with LBA 0: read performed; both held high after DONE → no second transfer until both drop.
- Reset asserted at index 200 of a read: next cycle sdAck=0, memRd=0, busy=0; following request restarts at sdA=0.
- Random memRdy delays of 0..7 cycles with a spurious memRdy while idle: data correct, memA/memD stable while pending, spurious pulse ignored.
